debounce_sync: RTL and testbench
================================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter STABLE_CYCLES, default 20000, number of consecutive cycles the synchronized input SHALL hold a new level before q changes; legal range 1..2^CNT_W.
REQ-002 Parameter CNT_W, default 16, width of the stability counter.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-005 Port D  input  1  raw asynchronous input (switch or external line); no timing relationship to clk.
REQ-006 Port q  output  1  debounced, synchronized level; registered.
REQ-007 Port rise  output  1  one-cycle pulse coincident with q going 0->1; registered.
REQ-008 Port fall  output  1  one-cycle pulse coincident with q going 1->0; registered.
REQ-009 Port busy  output  1  high while a candidate level change is being qualified (WAIT_HIGH or WAIT_LOW state); registered.

Function
REQ-010 D SHALL pass through exactly two synchronizer flops (s1, s2) before any other logic uses it; no combinational path from D to any output.
REQ-011 The FSM SHALL have four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW; state encoding is free.
REQ-012 IDLE_LOW: s2=1 -> WAIT_HIGH with cnt<=0; else stay.
REQ-013 WAIT_HIGH: s2=0 -> IDLE_LOW (bounce rejected, q unchanged, no pulse); else if cnt==STABLE_CYCLES-1 -> IDLE_HIGH, q<=1, rise<=1; else cnt<=cnt+1.
REQ-014 IDLE_HIGH: s2=0 -> WAIT_LOW with cnt<=0; else stay.
REQ-015 WAIT_LOW: s2=1 -> IDLE_HIGH (bounce rejected); else if cnt==STABLE_CYCLES-1 -> IDLE_LOW, q<=0, fall<=1; else cnt<=cnt+1.
REQ-016 rise and fall SHALL each be high for exactly one cycle per q transition and SHALL be low in every other cycle; rise and fall SHALL never be high together.
REQ-017 busy SHALL be high exactly in cycles where the registered state is WAIT_HIGH or WAIT_LOW.
REQ-018 Latency: if D is first sampled high at edge k and held, q and rise SHALL go high after edge k+STABLE_CYCLES+2 (2 sync stages, 1 cycle into WAIT, STABLE_CYCLES-1 count increments, 1 transition edge); falling direction symmetric.
REQ-019 A level on s2 lasting fewer than STABLE_CYCLES+1 consecutive cycles SHALL NOT change q or produce a pulse.
REQ-020 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL not wrap; with STABLE_CYCLES=1, q SHALL follow s2 one cycle after the WAIT state is entered.
REQ-021 A bounce that returns to the old level and then re-enters the new level SHALL restart qualification from cnt=0.

Reset
REQ-022 While rst=1 at a clock edge: s1, s2, cnt, q, rise, fall, busy SHALL be 0 and state SHALL be IDLE_LOW after that edge.
REQ-023 Reset asserted mid-qualification or while q=1 SHALL abort silently: q goes to 0 with no fall pulse.
REQ-024 rst SHALL take priority over every FSM transition in the same cycle.
REQ-025 If D is high when rst deasserts, q SHALL rise via the normal qualification path, with REQ-018 latency counted from the first edge with rst=0.

Verification (STABLE_CYCLES=4, CNT_W=3)
REQ-026 Clean step: rst released, D 0->1 sampled at edge 10, held -> q=1 and rise=1 after edge 16, rise=0 after edge 17, busy=1 after edges 12..15 inclusive.
REQ-027 Glitch rejection: with q=0, D high for 3 cycles then low -> q, rise, fall stay 0 throughout; busy pulses then returns to 0.
REQ-028 Bouncing release: with q=1, D toggles 1,0,1,0,0,0,0,0... -> exactly one fall pulse, q=0 no earlier than 6 edges after the last D 1->0 sample, no rise pulse.
REQ-029 Reset mid-operation: q=1, D driven low, rst=1 for one edge during WAIT_LOW -> all outputs 0 after that edge, no fall pulse, then D held low yields no further activity.
REQ-030 Reset with D high: rst high for 5 cycles with D=1, rst released at edge 20 -> q=1 and rise=1 after edge 26, single rise pulse.

Source files
------------

// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw external line and its debouncer.
// Ports: D (raw async level in), q (debounced level), rise/fall (edge pulses), busy (qualifying).
// master = side that drives D and consumes the results; slave = the debouncer itself.
interface debounce_sync_if;
  logic D;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output D,
    input  q,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  D,
    output q,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus stability-qualified debouncer for a raw external level.
// Ports: clk, rst (sync active-high), bus.D in; bus.q/rise/fall/busy out, all registered.
// Latency: q follows a held change of D STABLE_CYCLES+2 edges after D is first sampled.
module debounce_sync #(
  parameter int STABLE_CYCLES = 20000,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  debounce_sync_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  // Last count value of a qualification window; reaching it with the
  // candidate level still present commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= bus.D;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          // Bounce back to the committed level: drop the candidate silently.
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase

    // busy is registered alongside the state so it tracks the state register exactly.
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign bus.q    = q_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync with STABLE_CYCLES=4, CNT_W=3.
// Directed scenarios followed by randomized runs, every cycle compared to a run-length model.
// The model: q flips once the synchronized input has differed from q for STABLE_CYCLES+1 edges.
module tb_debounce_sync;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  debounce_sync_if bus ();

  debounce_sync #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int edge_n = 0;
  int n_rise = 0;
  int n_fall = 0;

  // Reference model state: D and rst as sampled on the last two edges,
  // committed level, pulses, and length of the current run of s2 != q.
  logic m_d1 = 1'b0, m_d2 = 1'b0;
  logic m_r1 = 1'b1, m_r2 = 1'b1;
  logic mq = 1'b0, mrise = 1'b0, mfall = 1'b0;
  int   mrun = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock edge with the given D/rst, then model update and full output check.
  task automatic tick(input logic d, input logic r);
    logic x;
    bus.D = d;
    rst   = r;
    @(posedge clk);
    edge_n++;
    // Synchronized level seen by the debouncer at this edge: D from two edges ago,
    // forced low if reset was applied on either of the two previous edges.
    x = (m_r1 || m_r2) ? 1'b0 : m_d2;
    m_d2 = m_d1; m_d1 = d;
    m_r2 = m_r1; m_r1 = r;
    mrise = 1'b0;
    mfall = 1'b0;
    if (r) begin
      mq   = 1'b0;
      mrun = 0;
    end else if (x != mq) begin
      mrun++;
      if (mrun == S + 1) begin
        mq    = x;
        mrise = x;
        mfall = ~x;
        mrun  = 0;
      end
    end else begin
      mrun = 0;
    end
    #1;
    chk("model_q",    bus.q,    mq);
    chk("model_rise", bus.rise, mrise);
    chk("model_fall", bus.fall, mfall);
    chk("model_busy", bus.busy, logic'(mrun != 0));
    if (bus.rise) n_rise++;
    if (bus.fall) n_fall++;
  endtask

  initial begin
    int m;
    int q0_edge;
    int r0;
    logic seen_busy;
    logic seq [12];

    bus.D = 1'b0;

    // Reset state.
    tick(1'b0, 1'b1);
    chk("reset_q", bus.q, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);

    // Clean step: D first sampled high at edge 10.
    for (int i = 4; i <= 9; i++) tick(1'b0, 1'b0);
    n_rise = 0;
    for (int i = 10; i <= 20; i++) begin
      tick(1'b1, 1'b0);
      chk("step_q",    bus.q,    logic'(edge_n >= 16));
      chk("step_rise", bus.rise, logic'(edge_n == 16));
      chk("step_busy", bus.busy, logic'(edge_n >= 12 && edge_n <= 15));
    end
    chk_int("step_rise_count", n_rise, 1);

    // Return low, then a 3-cycle glitch must be rejected.
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    chk("pre_glitch_q", bus.q, 1'b0);
    n_rise = 0; n_fall = 0; seen_busy = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick(logic'(i < 3), 1'b0);
      if (bus.busy) seen_busy = 1'b1;
      chk("glitch_q", bus.q, 1'b0);
    end
    chk("glitch_busy_seen", seen_busy, 1'b1);
    chk("glitch_busy_end", bus.busy, 1'b0);
    chk_int("glitch_pulses", n_rise + n_fall, 0);

    // Bouncing release from q=1.
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    chk("bounce_pre_q", bus.q, 1'b1);
    seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_rise = 0; n_fall = 0; m = 0; q0_edge = -1;
    for (int i = 0; i < 12; i++) begin
      tick(seq[i], 1'b0);
      if (i == 3) m = edge_n;
      if (!bus.q && q0_edge < 0) q0_edge = edge_n;
    end
    chk_int("bounce_fall_count", n_fall, 1);
    chk_int("bounce_rise_count", n_rise, 0);
    chk_int("bounce_q0_edge", q0_edge, m + S + 2);

    // Reset during WAIT_LOW.
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    chk("rstmid_pre_q", bus.q, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    chk("rstmid_busy", bus.busy, 1'b1);
    n_rise = 0; n_fall = 0;
    tick(1'b0, 1'b1);
    chk("rstmid_q", bus.q, 1'b0);
    chk("rstmid_busy0", bus.busy, 1'b0);
    chk("rstmid_fall", bus.fall, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      chk("rstmid_idle_busy", bus.busy, 1'b0);
    end
    chk_int("rstmid_pulses", n_rise + n_fall, 0);

    // Reset held with D high; qualification counts from the first edge with rst=0.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    n_rise = 0;
    r0 = edge_n + 1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      chk("rsthi_q",    bus.q,    logic'(edge_n >= r0 + S + 2));
      chk("rsthi_rise", bus.rise, logic'(edge_n == r0 + S + 2));
    end
    chk_int("rsthi_rise_count", n_rise, 1);

    // Randomized runs of random length, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic lvl;
      int   len;
      lvl = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * S + 1);
      for (int j = 0; j < len; j++) begin
        tick(lvl, logic'($urandom_range(0, 99) == 0));
        chk("rand_excl", bus.rise & bus.fall, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
